// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int   OVERSAMPLE_DEFAULT = 16;
  localparam logic LINE_IDLE          = 1'b1;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART TX arbiter: requests/data in, grant/status/line out.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic [$clog2(NUM_REQ)-1:0]   owner;
  logic                         busy;
  logic                         done;
  logic                         tx;

  modport master (output req, req_data, input gnt, owner, busy, done, tx);
  modport slave  (input req, req_data, output gnt, owner, busy, done, tx);
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    index = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(rr_ptr) + k) % N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART transmitter shared by NUM_REQ requesters; round-robin grant, 8N1-style framing
// timed by an oversampling tick from the baud generator.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [DATA_BITS-1:0] shift;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IW-1:0]        owner_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tx_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [DATA_BITS-1:0] sel_data;
  logic                 bit_end;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .index  (arb_idx),
    .valid  (arb_valid)
  );

  assign sel_data = bus.req_data[arb_idx*DATA_BITS +: DATA_BITS];

  // The tick that would bring tick_cnt to OVERSAMPLE closes the current bit.
  assign bit_end = tick && (tick_cnt == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      shift    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      gnt_q    <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= LINE_IDLE;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;

      if (state != IDLE && tick)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          tx_q <= LINE_IDLE;
          if (arb_valid) begin
            gnt_q    <= arb_grant;
            shift    <= sel_data;
            owner_q  <= arb_idx;
            busy_q   <= 1'b1;
            tx_q     <= ~LINE_IDLE;
            tick_cnt <= '0;
            rr_ptr   <= IW'(wrap_inc(int'(arb_idx), NUM_REQ));
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx_q    <= shift[0];
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              stop_cnt <= 1'b0;
              tx_q     <= LINE_IDLE;
              state    <= STOP;
            end else begin
              tx_q <= shift[1];
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter; frames checked against a round-robin model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int FRAME_TICKS = OS * (DB + 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick  = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_BITS(DB), .STOP_BITS(1), .OVERSAMPLE(OS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scaled baud: one tick every 4 clocks, free-running through reset.
  int tdiv = 0;
  always @(negedge clk) begin
    tdiv = (tdiv + 1) % 4;
    tick = (tdiv == 0);
  end

  int tick_seen = 0;
  always @(posedge clk) if (tick) tick_seen++;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int pulse_at = -1;
  bit scramble = 1'b0;
  logic [7:0] bytes [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++)
      if (r[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    return -1;
  endfunction

  task automatic set_data();
    bus.req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ptr_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for the next grant, then samples every bit at its tick midpoint.
  task automatic run_frame(input logic [NR-1:0] req_next);
    int exp_idx;
    logic [DB+1:0] fr;
    int t0, n, last;
    bit got;
    exp_idx = model_pick(bus.req);
    fr = {1'b1, bytes[exp_idx < 0 ? 0 : exp_idx], 1'b0};
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (bus.gnt !== '0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("gnt_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("gnt_onehot", 32'(bus.gnt), 32'(1 << exp_idx));
    chk("owner", 32'(bus.owner), 32'(exp_idx));
    chk("busy_at_gnt", 32'(bus.busy), 32'd1);
    chk("tx_falls_at_gnt", 32'(bus.tx), 32'd0);
    ptr_m = (exp_idx + 1) % NR;
    bus.req = req_next;
    if (scramble) begin
      for (int i = 0; i < NR; i++) bytes[i] = 8'($urandom);
      set_data();
    end
    t0 = tick_seen;
    last = 0;
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (pulse_at >= 0) begin
        if (k == pulse_at) bus.req[3] = 1'b1;
        if (k == pulse_at + 5) bus.req[3] = 1'b0;
      end
      n = tick_seen - t0;
      if (n != last) begin
        last = n;
        chk("no_gnt_while_busy", 32'(bus.gnt), 32'd0);
        if (n % OS == OS / 2)
          chk($sformatf("tx_bit%0d", n / OS), 32'(bus.tx), 32'(fr[n / OS]));
        if (n == FRAME_TICKS) begin
          chk("done_at_end", 32'(bus.done), 32'd1);
          chk("busy_clear", 32'(bus.busy), 32'd0);
          chk("tx_idle_at_done", 32'(bus.tx), 32'd1);
          break;
        end else begin
          chk("no_early_done", 32'(bus.done), 32'd0);
        end
      end
    end
    if (n != FRAME_TICKS) chk("frame_timeout", 32'(n), 32'(FRAME_TICKS));
    @(negedge clk);
    chk("done_one_clk", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    bit got;
    bus.req = '0;
    for (int i = 0; i < NR; i++) bytes[i] = 8'($urandom);
    set_data();

    // 1: reset state and quiet idle with ticks running
    repeat (2) @(negedge clk);
    chk("reset_state", {23'd0, bus.tx, bus.gnt, bus.busy, bus.done, bus.owner}, {23'd0, 1'b1, 4'b0, 1'b0, 1'b0, 2'b0});
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_quiet", {23'd0, bus.tx, bus.gnt, bus.busy, bus.done, bus.owner}, {23'd0, 1'b1, 4'b0, 1'b0, 1'b0, 2'b0});
    end

    // 2: single request, byte A5
    bytes[1] = 8'hA5;
    set_data();
    bus.req = 4'b0010;
    run_frame(4'b0000);

    // 3: all requesting from a fresh pointer
    do_reset();
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'h0F;
    set_data();
    bus.req = 4'b1111;
    for (int f = 0; f < 4; f++) run_frame(4'b1111);
    run_frame(4'b0000);

    // 4: two requesters alternate, random bytes
    scramble = 1'b1;
    bus.req = 4'b0101;
    for (int f = 0; f < 4; f++) run_frame(4'b0101);
    run_frame(4'b0000);

    // 5: reset during data bit 3
    bus.req = 4'b0001;
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.gnt !== '0) begin got = 1'b1; break; end
    end
    chk("abort_gnt_seen", 32'(got), 32'd1);
    bus.req = 4'b0000;
    t0 = tick_seen;
    for (int k = 0; k < 1000; k++) begin
      if (tick_seen - t0 >= 4 * OS + OS / 2) break;
      @(negedge clk);
    end
    rst_n = 1'b0;
    ptr_m = 0;
    #1;
    chk("abort_tx_high", 32'(bus.tx), 32'd1);
    chk("abort_busy_low", 32'(bus.busy), 32'd0);
    chk("abort_gnt_low", 32'(bus.gnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    bus.req = 4'b0100;
    run_frame(4'b0000);

    // 6: short req[3] pulse while busy is lost
    bus.req = 4'b0001;
    pulse_at = 100;
    run_frame(4'b0000);
    pulse_at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("post_pulse_idle", {28'd0, bus.tx, bus.gnt[3], bus.busy, bus.done}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    end

    // Random request patterns
    for (int f = 0; f < 4; f++) begin
      bus.req = 4'($urandom_range(1, 15));
      run_frame(4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
